lc3_mem_arbiter: RTL and testbench
==================================

# lc3_mem_arbiter

Two-port arbiter that shares the LC-3 single-port data/instruction memory between the CPU's MAR/MDR path and an external loader/debug port (program load, memory inspection). Sits between the control/datapath and the memory array. Serialises one transaction at a time through a fixed-latency access window and returns a one-cycle acknowledge plus captured read data to the winning requester.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, memory access cycles per transaction, legal range 1..7

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, held until next CPU read completes
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external port, same rules as CPU
- ext_ack  out  1  one-cycle completion pulse
- ext_rdata  out  DATA_W  read data, held until next external read completes
- mem_en  out  1  memory enable, high during the access window
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the last access cycle
- busy  out  1  high in any state other than IDLE
- grant_ext  out  1  current or last transaction belongs to the external port

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any request is pending, select the winner; latch we, addr, wdata; load the latency counter with MEM_LAT-1; go to ACCESS. With no request, stay in IDLE.
- Arbitration on a simultaneous request: see Configuration. A single request always wins.
- ACCESS: mem_en=1; mem_we=latched we; mem_addr and mem_wdata come from the latches. Decrement the counter each cycle. When the counter is 0, capture mem_rdata into the winner's rdata register (reads only) and go to DONE.
- DONE: assert the winner's ack for exactly one cycle, then go to IDLE.
- Latched fields are immune to requester changes after the grant. If req is dropped mid-transaction, the access still completes and ack still pulses.
- A requester must deassert req on the edge where it sees ack. Any req still high in the following IDLE cycle is a new transaction.
- Write transactions leave the rdata registers unchanged.
- Reset values: state IDLE; cpu_ack, ext_ack, mem_en, mem_we, busy, grant_ext = 0; mem_addr, mem_wdata, cpu_rdata, ext_rdata = 0; round-robin pointer set to favour the CPU.
- Reset mid-transaction: the transaction is aborted at that edge. No ack is issued and mem_en/mem_we are 0 in the next cycle. The transaction is not retried.

## Timing
- Request seen in IDLE at cycle 0 → ACCESS in cycles 1..MEM_LAT → ack in cycle MEM_LAT+1 → IDLE in cycle MEM_LAT+2.
- Rdata is valid in the ack cycle and stays stable afterwards.
- Throughput: one transaction per MEM_LAT+2 cycles. There is no back-to-back access without an IDLE cycle.
- mem_* outputs are driven from the state and latch registers only. There is no combinational path from req to mem_*.
- MEM_LAT=1: the ACCESS state lasts exactly one cycle.

## Configuration
- LC3_ARB_ROUND_ROBIN_EN defined: when both ports request in IDLE, the port not granted last wins. The pointer updates on every grant.
- Undefined: fixed priority, CPU always wins a tie. External requests can starve while cpu_req stays continuously high.

## Test plan
- CPU read, MEM_LAT=2, addr 0x3000, memory holds 0x1234 → mem_en high cycles 1-2, cpu_ack in cycle 3, cpu_rdata=0x1234, ext_ack never asserted.
- External write addr 0x0200 data 0xBEEF, then CPU read of 0x0200 → mem_we high only in the external window, and cpu_rdata=0xBEEF.
- Both requesting continuously, CPU last served, round-robin build → grant order ext, cpu, ext, cpu. Fixed-priority build → cpu every time and ext_ack stays 0.
- CPU drops req during the second ACCESS cycle → the access completes and cpu_ack still pulses in cycle 3.
- Reset asserted in the first ACCESS cycle of a write → next cycle: state IDLE, mem_en=0, mem_we=0, no ack, busy=0.
- MEM_LAT=1, CPU read then immediate ext read → acks in cycles 2 and 5, and busy low in cycle 3.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// Two-port arbiter sharing the LC-3 single-port memory between the CPU and an external loader/debug port.
// Tie-break mode: define LC3_ARB_ROUND_ROBIN_EN for round-robin, otherwise the CPU has fixed priority.
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_ext,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req (and its fields) until it sees a one-cycle ack,
  // and drops req on that same edge; req still high in the next IDLE cycle is a new transaction.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t            state;
  state_t            state_next;
  logic [2:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              pick_ext;
  logic              any_req;

  assign any_req = cpu_req | ext_req;

`ifdef LC3_ARB_ROUND_ROBIN_EN
  // last_ext records the port granted most recently; reset value 1 lets the CPU win the first tie.
  logic last_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ext <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_ext <= pick_ext;
    end
  end

  always_comb begin
    pick_ext = ext_req & (~cpu_req | ~last_ext);
  end
`else
  always_comb begin
    pick_ext = ext_req & ~cpu_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (cnt == 3'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    ext_ack   = 1'b0;
    busy      = 1'b0;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    dbg_state = state;
    case (state)
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = lat_we;
        busy   = 1'b1;
      end
      DONE: begin
        cpu_ack = ~grant_ext;
        ext_ack = grant_ext;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  // Fields are latched at grant so the requester may change its inputs freely afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 3'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      grant_ext <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_ext <= pick_ext;
            lat_we    <= pick_ext ? ext_we    : cpu_we;
            lat_addr  <= pick_ext ? ext_addr  : cpu_addr;
            lat_wdata <= pick_ext ? ext_wdata : cpu_wdata;
            cnt       <= LAT_INIT;
          end
        end
        ACCESS: begin
          if (cnt == 3'd0) begin
            if (!lat_we) begin
              if (grant_ext) ext_rdata <= mem_rdata;
              else           cpu_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: behavioural memory, reference data model and
// per-scenario tasks; a second instance with MEM_LAT=1 covers the minimum-latency case.
module tb_lc3_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_ack, ext_ack, mem_en, mem_we, busy, grant_ext;
  logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  logic        cpu_req_1, ext_req_1;
  logic [15:0] cpu_addr_1, ext_addr_1;
  logic        cpu_ack_1, ext_ack_1, mem_en_1, mem_we_1, busy_1, grant_ext_1;
  logic [15:0] cpu_rdata_1, ext_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic [1:0]  dbg_state_1;

  int checks = 0;
  int errors = 0;

  // Reference model: bench-issued writes plus the known initial memory image.
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_q [$];
  logic [15:0] exp_cpu_rd, exp_ext_rd;
  logic        last_ext;

  logic [15:0] mem_arr [0:65535];
  bit          wr_valid [0:65535];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_init(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5C3);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  assign mem_rdata   = wr_valid[mem_addr] ? mem_arr[mem_addr] : mem_init(mem_addr);
  assign mem_rdata_1 = mem_init(mem_addr_1);

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr]  <= mem_wdata;
      wr_valid[mem_addr] <= 1'b1;
    end
  end

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_ext(grant_ext), .dbg_state(dbg_state)
  );

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut_1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req_1), .cpu_we(1'b0), .cpu_addr(cpu_addr_1), .cpu_wdata(16'h0000),
    .cpu_ack(cpu_ack_1), .cpu_rdata(cpu_rdata_1),
    .ext_req(ext_req_1), .ext_we(1'b0), .ext_addr(ext_addr_1), .ext_wdata(16'h0000),
    .ext_ack(ext_ack_1), .ext_rdata(ext_rdata_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .busy(busy_1), .grant_ext(grant_ext_1), .dbg_state(dbg_state_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_ext   = 1'b1;
    exp_cpu_rd = 16'h0000;
    exp_ext_rd = 16'h0000;
  endtask

  task automatic apply_reset();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    cpu_req_1 = 0; ext_req_1 = 0; cpu_addr_1 = 0; ext_addr_1 = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    model_reset();
  endtask

  // One transaction from an idle arbiter, checked cycle by cycle against the timing rules.
  task automatic do_txn(input bit port_ext, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata);
    logic [15:0] exp_rd;
    if (port_ext) begin
      ext_req = 1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    if (!we) exp_q.push_back(ref_read(addr));
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      if (k <= LAT) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== we || mem_addr !== addr || busy !== 1'b1 ||
            grant_ext !== port_ext || cpu_ack !== 1'b0 || ext_ack !== 1'b0) begin
          errors++;
          $display("FAIL txn_access cyc=%0d en=%b we=%b addr=%h busy=%b gnt=%b acks=%b%b exp we=%b addr=%h gnt=%b",
                   k, mem_en, mem_we, mem_addr, busy, grant_ext, cpu_ack, ext_ack, we, addr, port_ext);
        end
        if (we) begin
          checks++;
          if (mem_wdata !== wdata) begin
            errors++;
            $display("FAIL txn_wdata got %h exp %h", mem_wdata, wdata);
          end
        end
      end else if (k == LAT + 1) begin
        if (!we) begin
          exp_rd = exp_q.pop_front();
          if (port_ext) exp_ext_rd = exp_rd;
          else          exp_cpu_rd = exp_rd;
        end
        checks++;
        if (cpu_ack !== !port_ext || ext_ack !== port_ext || mem_en !== 1'b0) begin
          errors++;
          $display("FAIL txn_ack cpu_ack=%b ext_ack=%b mem_en=%b exp cpu_ack=%b ext_ack=%b",
                   cpu_ack, ext_ack, mem_en, !port_ext, port_ext);
        end
        checks++;
        if (cpu_rdata !== exp_cpu_rd || ext_rdata !== exp_ext_rd) begin
          errors++;
          $display("FAIL txn_rdata cpu=%h ext=%h exp cpu=%h ext=%h",
                   cpu_rdata, ext_rdata, exp_cpu_rd, exp_ext_rd);
        end
        cpu_req = 0;
        ext_req = 0;
      end else begin
        checks++;
        if (busy !== 1'b0 || cpu_ack !== 1'b0 || ext_ack !== 1'b0 || mem_en !== 1'b0) begin
          errors++;
          $display("FAIL txn_idle busy=%b acks=%b%b en=%b exp all 0", busy, cpu_ack, ext_ack, mem_en);
        end
      end
    end
    if (we) ref_mem[addr] = wdata;
    last_ext = port_ext;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dbg_state !== 2'd0 || cpu_ack !== 0 || ext_ack !== 0 || mem_en !== 0 || mem_we !== 0 ||
        busy !== 0 || grant_ext !== 0 || mem_addr !== 0 || mem_wdata !== 0 ||
        cpu_rdata !== 0 || ext_rdata !== 0) begin
      errors++;
      $display("FAIL reset_values st=%0d acks=%b%b en=%b we=%b busy=%b gnt=%b addr=%h wd=%h rd=%h/%h exp all 0",
               dbg_state, cpu_ack, ext_ack, mem_en, mem_we, busy, grant_ext, mem_addr,
               mem_wdata, cpu_rdata, ext_rdata);
    end
  endtask

  task automatic test_cpu_read();
    do_txn(1'b0, 1'b0, 16'h3000, 16'h0000);
    checks++;
    if (cpu_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL cpu_read_3000 got %h exp 1234", cpu_rdata);
    end
  endtask

  task automatic test_ext_write_cpu_read();
    do_txn(1'b1, 1'b1, 16'h0200, 16'hBEEF);
    do_txn(1'b0, 1'b0, 16'h0200, 16'h0000);
    checks++;
    if (cpu_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_then_read got %h exp beef", cpu_rdata);
    end
  endtask

  // Both ports hold req continuously; four grants are observed via the acks.
  task automatic test_arbitration();
    logic [15:0] ca, ea;
    bit          got, exp_ext;
    ca = 16'h5000 + 16'($urandom_range(0, 255));
    ea = 16'h6000 + 16'($urandom_range(0, 255));
    cpu_we = 0; ext_we = 0; cpu_addr = ca; ext_addr = ea;
    cpu_req = 1; ext_req = 1;
    for (int t = 0; t < 4; t++) begin
`ifdef LC3_ARB_ROUND_ROBIN_EN
      exp_ext = !last_ext;
`else
      exp_ext = 1'b0;
`endif
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        tick();
        if (cpu_ack || ext_ack) begin
          got = 1;
          if (exp_ext) exp_ext_rd = ref_read(ea);
          else         exp_cpu_rd = ref_read(ca);
          checks++;
          if (ext_ack !== exp_ext || cpu_ack !== !exp_ext) begin
            errors++;
            $display("FAIL arb_order grant=%0d cpu_ack=%b ext_ack=%b exp ext=%b", t, cpu_ack, ext_ack, exp_ext);
          end
          checks++;
          if (cpu_rdata !== exp_cpu_rd || ext_rdata !== exp_ext_rd) begin
            errors++;
            $display("FAIL arb_rdata cpu=%h ext=%h exp cpu=%h ext=%h", cpu_rdata, ext_rdata, exp_cpu_rd, exp_ext_rd);
          end
          if (t == 3) begin
            cpu_req = 0;
            ext_req = 0;
          end
        end
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL arb_timeout grant=%0d no ack within 20 cycles", t);
      end
      last_ext = exp_ext;
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL arb_settle busy=%b exp 0", busy);
    end
  endtask

  // Requester scribbles on its inputs and drops req mid-access; the latched access must finish.
  task automatic test_req_drop();
    logic [15:0] a;
    a = 16'h4100 + 16'($urandom_range(0, 63));
    cpu_we = 0; cpu_addr = a; cpu_req = 1;
    tick();
    cpu_addr = ~a; cpu_we = 1;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a) begin
      errors++;
      $display("FAIL drop_latched en=%b we=%b addr=%h exp en=1 we=0 addr=%h", mem_en, mem_we, mem_addr, a);
    end
    cpu_req = 0;
    tick();
    exp_cpu_rd = ref_read(a);
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== exp_cpu_rd) begin
      errors++;
      $display("FAIL drop_ack ack=%b rdata=%h exp ack=1 rdata=%h", cpu_ack, cpu_rdata, exp_cpu_rd);
    end
    cpu_we = 0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_retry busy=%b ack=%b exp 0 0", busy, cpu_ack);
    end
    last_ext = 1'b0;
  endtask

  task automatic test_reset_mid();
    cpu_we = 1; cpu_addr = 16'h7FFF; cpu_wdata = 16'($urandom); cpu_req = 1;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_start en=%b we=%b exp 1 1", mem_en, mem_we);
    end
    reset = 1; cpu_req = 0;
    tick();
    reset = 0;
    model_reset();
    checks++;
    if (dbg_state !== 2'd0 || mem_en !== 0 || mem_we !== 0 || cpu_ack !== 0 || busy !== 0 ||
        cpu_rdata !== 0 || grant_ext !== 0) begin
      errors++;
      $display("FAIL rstmid_abort st=%0d en=%b we=%b ack=%b busy=%b rd=%h gnt=%b exp all 0",
               dbg_state, mem_en, mem_we, cpu_ack, busy, cpu_rdata, grant_ext);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (cpu_ack !== 0 || ext_ack !== 0 || busy !== 0) begin
        errors++;
        $display("FAIL rstmid_quiet cyc=%0d acks=%b%b busy=%b exp 0", k, cpu_ack, ext_ack, busy);
      end
    end
    cpu_we = 0;
  endtask

  task automatic test_lat1();
    logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    cpu_addr_1 = a; cpu_req_1 = 1;
    tick();
    checks++;
    if (mem_en_1 !== 1'b1 || mem_addr_1 !== a) begin
      errors++;
      $display("FAIL lat1_access en=%b addr=%h exp 1 %h", mem_en_1, mem_addr_1, a);
    end
    tick();
    checks++;
    if (cpu_ack_1 !== 1'b1 || mem_en_1 !== 1'b0 || cpu_rdata_1 !== mem_init(a)) begin
      errors++;
      $display("FAIL lat1_cpu_ack ack=%b en=%b rd=%h exp 1 0 %h", cpu_ack_1, mem_en_1, cpu_rdata_1, mem_init(a));
    end
    cpu_req_1 = 0; ext_addr_1 = b; ext_req_1 = 1;
    tick();
    checks++;
    if (busy_1 !== 1'b0 || ext_ack_1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_idle busy=%b ext_ack=%b exp 0 0", busy_1, ext_ack_1);
    end
    tick();
    checks++;
    if (mem_en_1 !== 1'b1 || mem_addr_1 !== b || ext_ack_1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_ext_access en=%b addr=%h ack=%b exp 1 %h 0", mem_en_1, mem_addr_1, ext_ack_1, b);
    end
    tick();
    checks++;
    if (ext_ack_1 !== 1'b1 || cpu_ack_1 !== 1'b0 || ext_rdata_1 !== mem_init(b) || cpu_rdata_1 !== mem_init(a)) begin
      errors++;
      $display("FAIL lat1_ext_ack ack=%b cpu_ack=%b rd=%h/%h exp 1 0 %h/%h",
               ext_ack_1, cpu_ack_1, ext_rdata_1, cpu_rdata_1, mem_init(b), mem_init(a));
    end
    ext_req_1 = 0;
    tick();
    checks++;
    if (busy_1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_end busy=%b exp 0", busy_1);
    end
  endtask

  task automatic test_random();
    bit          p, w;
    logic [15:0] a;
    for (int n = 0; n < 24; n++) begin
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 16'h4000 + 16'($urandom_range(0, 7));
      do_txn(p, w, a, 16'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ext_write_cpu_read();
    test_arbitration();
    test_req_drop();
    test_reset_mid();
    test_lat1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
